fetch: RTL and testbench

- Instruction-fetch stage. Owns the PC, issues one-outstanding-request reads on the instruction bus, and registers `fetch_data_t dataF` (valid, pc, raw_instr) into decode.
- Honours the decode/execute/memory stalls (`stopd`, `stope`, `stopm`) and branch redirects.
- Squashes in-flight fetches on redirect without aborting the bus transaction.

---
 rtl/fetch.sv | 117 +++++++++++
 tb/tb_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one read outstanding
// on the instruction bus and registers fetched words into decode.
package fetch_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;

endpackage

module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stopd,
  input  logic        stope,
  input  logic        stopm,
  input  logic        branch,
  input  logic [63:0] branch_target,
  output fetch_data_t dataF
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DISCARD
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] stale_addr;
  logic [31:0] buf_instr;
  logic        accept;

  assign accept = !(stopd | stope | stopm);

  // Bus request is a pure decode of the registered state.
  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = pc;
    unique case (state)
      REQ: ireq_valid = 1'b1;
      DISCARD: begin
        ireq_valid = 1'b1;
        ireq_addr  = stale_addr;
      end
      default: ireq_valid = 1'b0;
    endcase
  end

  // Fetch FSM: PC sequencing, parking, squash and dataF register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      stale_addr <= '0;
      buf_instr  <= '0;
      dataF      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (branch) pc <= branch_target;
          state <= REQ;
        end
        REQ: begin
          if (branch) begin
            pc <= branch_target;
            if (!iresp_data_ok) begin
              stale_addr <= pc;
              state      <= DISCARD;
            end
          end else if (iresp_data_ok) begin
            if (accept) begin
              dataF <= '{valid: 1'b1, pc: pc,
                         raw_instr: iresp_data};
              pc    <= pc + 64'd4;
            end else begin
              buf_instr <= iresp_data;
              state     <= HOLD;
            end
          end else if (accept) begin
            dataF.valid <= 1'b0;
          end
        end
        HOLD: begin
          if (branch) begin
            pc    <= branch_target;
            state <= REQ;
          end else if (accept) begin
            dataF <= '{valid: 1'b1, pc: pc,
                       raw_instr: buf_instr};
            pc    <= pc + 64'd4;
            state <= REQ;
          end
        end
        DISCARD: begin
          if (branch) pc <= branch_target;
          if (iresp_data_ok) state <= REQ;
          if (accept) dataF.valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (branch) dataF.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for fetch: bus responder with random latency and
// an in-order instruction-stream model of what decode should see.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [63:0] PCR = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        stopd = 1'b0;
  logic        stope = 1'b0;
  logic        stopm = 1'b0;
  logic        branch = 1'b0;
  logic [63:0] branch_target = '0;
  fetch_data_t dataF;

  fetch #(.PC_RESET(PCR)) dut (
    .clk(clk),
    .reset(reset),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .stopd(stopd),
    .stope(stope),
    .stopm(stopm),
    .branch(branch),
    .branch_target(branch_target),
    .dataF(dataF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h13;
  endfunction

  // stream model
  logic [63:0] exp_pc;
  bit          have_word;
  // bus model
  bit          pending, pend_sq, late;
  logic [63:0] req_addr;
  int          wait_left;
  // inputs applied for the coming edge
  bit          c_acc, c_br, c_ok, c_sq;
  logic [63:0] c_tgt;
  logic [31:0] c_data;
  fetch_data_t prev_df;
  // knobs
  int lat_lo, lat_hi, stall_pct, br_pct;
  int delivered = 0;

  task automatic expect_deliver(input logic [31:0] w);
    check("valid", 128'(dataF.valid), 128'(1));
    check("pc", 128'(dataF.pc), 128'(exp_pc));
    check("instr", 128'(dataF.raw_instr), 128'(w));
    check("instr_mem", 128'(w), 128'(mem(exp_pc)));
    exp_pc = exp_pc + 64'd4;
    delivered++;
  endtask

  task automatic check_edge();
    if (c_br) begin
      check("br_valid", 128'(dataF.valid), 128'(0));
    end else if (c_acc) begin
      if (have_word) begin
        expect_deliver(mem(exp_pc));
        have_word = 0;
      end else if (c_ok && !c_sq) begin
        expect_deliver(c_data);
      end else begin
        check("bubble", 128'(dataF.valid), 128'(0));
      end
    end else begin
      check("hold", 128'(dataF), 128'(prev_df));
      if (c_ok && !c_sq) have_word = 1;
    end
    if (c_br) begin
      exp_pc = c_tgt;
      have_word = 0;
      if (pending && !c_ok) pend_sq = 1;
    end
    if (c_ok) begin
      pending = 0;
      late = 0;
    end
    prev_df = dataF;
  endtask

  task automatic drive();
    int r;
    r = $urandom_range(99);
    stopd = 0;
    stope = 0;
    stopm = 0;
    if (r < stall_pct) begin
      case ($urandom_range(2))
        0: stopd = 1;
        1: stope = 1;
        default: stopm = 1;
      endcase
    end
    c_acc = !(stopd | stope | stopm);
    c_br = ($urandom_range(99) < br_pct);
    if ($urandom_range(7) == 0)
      c_tgt = 64'hFFFF_FFFF_FFFF_FFF0;
    else
      c_tgt = {32'($urandom), 32'($urandom)} & ~64'd3;
    branch = c_br;
    branch_target = c_tgt;
    if (have_word)
      check("hold_noreq", 128'(ireq_valid), 128'(0));
    if (!pending && ireq_valid) begin
      pending = 1;
      pend_sq = 0;
      late = 0;
      req_addr = ireq_addr;
      wait_left = $urandom_range(lat_hi, lat_lo);
      check("req_addr", 128'(ireq_addr), 128'(exp_pc));
    end else if (pending && !late) begin
      check("req_stable_v", 128'(ireq_valid), 128'(1));
      check("req_stable_a", 128'(ireq_addr), 128'(req_addr));
    end
    if (pending && wait_left == 0) begin
      c_ok = 1;
      c_data = mem(req_addr);
    end else begin
      c_ok = 0;
      c_data = $urandom;
      if (pending) wait_left--;
    end
    c_sq = pend_sq;
    iresp_data_ok = c_ok;
    iresp_data = c_data;
  endtask

  task automatic reset_pulse();
    #2 reset = 0;
    #1;
    check("rst_ireq", 128'(ireq_valid), 128'(0));
    check("rst_valid", 128'(dataF.valid), 128'(0));
    iresp_data_ok = 0;
    branch = 0;
    @(negedge clk);
    reset = 1;
    exp_pc = PCR;
    have_word = 0;
    pending = 1;
    pend_sq = 1;
    late = 1;
    wait_left = 0;
    prev_df = dataF;
  endtask

  task automatic run(input int n, input int llo, input int lhi,
                     input int sp, input int bp, input int rst_every);
    lat_lo = llo;
    lat_hi = lhi;
    stall_pct = sp;
    br_pct = bp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_edge();
      if (rst_every > 0 && i % rst_every == rst_every - 1)
        reset_pulse();
      drive();
    end
  endtask

  initial begin
    #3;
    check("rst_ireq0", 128'(ireq_valid), 128'(0));
    check("rst_dataF0", 128'(dataF), 128'(0));
    @(negedge clk);
    reset = 1;
    exp_pc = PCR;
    have_word = 0;
    pending = 0;
    pend_sq = 0;
    late = 0;
    prev_df = dataF;
    lat_lo = 0;
    lat_hi = 0;
    stall_pct = 0;
    br_pct = 0;
    drive();
    run(50, 0, 0, 0, 0, 0);
    run(60, 3, 3, 0, 0, 0);
    run(400, 0, 3, 30, 0, 0);
    run(1500, 0, 3, 30, 10, 300);
    run(1000, 0, 2, 50, 20, 0);
    @(negedge clk);
    check_edge();
    if (delivered < 200)
      check("delivered_min", 128'(delivered >= 200), 128'(1));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
